// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin write arbiter that lets N_REQ valid/ready producers share the
// single write port of a fifo_buffer. A producer that wins arbitration keeps
// the port for a burst of up to MAX_BURST beats. It gives the port up early
// when it stops presenting data.
//
// Timing summary:
//   - Arbitration takes one edge, so a new owner can transfer in the cycle
//     after the one in which it first presented valid.
//   - Every release is followed by one IDLE cycle before the next grant.
//   - The data path is purely combinational. The FIFO samples wr_en/data on
//     the same edge that completes the producer handshake.
module fifo_wr_arbiter #(
  parameter int N_REQ      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [N_REQ-1:0]              req_valid_i,
  input  logic [N_REQ*DATA_WIDTH-1:0]   req_data_i,
  output logic [N_REQ-1:0]              req_ready_o,
  input  logic                          fifo_full_i,
  output logic                          fifo_wr_en_o,
  output logic [DATA_WIDTH-1:0]         fifo_data_o,
  output logic [N_REQ-1:0]              grant_o,
  output logic [$clog2(N_REQ)-1:0]      grant_id_o,
  output logic                          busy_o
);

  localparam int ID_W = $clog2(N_REQ);

  // A burst ends on the beat whose pre-increment count equals this value.
  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]   grant_id_q, grant_id_d;
  logic [7:0]        beat_cnt_q, beat_cnt_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

  logic              pick_found;
  logic [ID_W-1:0]   pick_id;
  logic              owner_valid;
  logic              xfer;
  logic              last_beat;
  logic              release_burst;

  // Round-robin search. Start one past the previous owner and take the
  // first requester that is presenting valid.
  always_comb begin
    int idx;
    logic [ID_W-1:0] idx_b;
    pick_found = 1'b0;
    pick_id    = '0;
    idx        = 0;
    idx_b      = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx   = (int'(rr_ptr_q) + k) % N_REQ;
      idx_b = idx[ID_W-1:0];
      if (!pick_found && req_valid_i[idx_b]) begin
        pick_found = 1'b1;
        pick_id    = idx_b;
      end
    end
  end

  // Owner handshake. A beat moves only while we are in BURST, the owner
  // has data, and the FIFO has room.
  always_comb begin
    owner_valid   = req_valid_i[grant_id_q];
    xfer          = (state_q == BURST) && owner_valid && !fifo_full_i;
    last_beat     = (beat_cnt_q == LAST_BEAT);
    release_burst = (state_q == BURST) && ((xfer && last_beat) || !owner_valid);
  end

  // Next-state logic for the IDLE/BURST controller. While the FIFO is full
  // the grant and beat count hold with no timeout. An owner that stops
  // presenting valid gives the port up immediately.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    beat_cnt_d = beat_cnt_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = BURST;
          grant_d    = {{(N_REQ-1){1'b0}}, 1'b1} << pick_id;
          grant_id_d = pick_id;
          beat_cnt_d = '0;
        end
      end
      BURST: begin
        if (xfer) begin
          beat_cnt_d = beat_cnt_q + 8'd1;
        end
        if (release_burst) begin
          state_d    = IDLE;
          grant_d    = '0;
          beat_cnt_d = '0;
          rr_ptr_d   = grant_id_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State register. The async reset abandons any partial burst. The
  // pointer resets to the top index so requester 0 has first priority.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      rr_ptr_q   <= ID_W'(N_REQ - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Combinational port steering. All of it is gated by the registered
  // state, so it drops to zero as soon as reset forces the state to IDLE.
  always_comb begin
    req_ready_o  = '0;
    fifo_wr_en_o = 1'b0;
    fifo_data_o  = '0;
    if (state_q == BURST) begin
      req_ready_o[grant_id_q] = !fifo_full_i;
      fifo_wr_en_o            = xfer;
      fifo_data_o             = req_data_i[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign grant_o    = grant_q;
  assign grant_id_o = grant_id_q;
  assign busy_o     = (state_q == BURST);

  // Structural invariants of the grant and the write port.
  a_grant_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(grant_q));
  a_ready_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
    $onehot0(req_ready_o));
  a_wr_not_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
    fifo_wr_en_o |-> !fifo_full_i);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Scoreboard bench for fifo_wr_arbiter. The producers are queues of words.
// A transaction-level model turns the queue contents into the expected
// order of FIFO writes. A negedge monitor pops and compares each write.
module tb_fifo_wr_arbiter;

  localparam int N_REQ      = 4;
  localparam int DATA_WIDTH = 8;
  localparam int MAX_BURST  = 4;
  localparam int ID_W       = 2;

  logic                        clk_i = 1'b0;
  logic                        rst_ni;
  logic [N_REQ-1:0]            req_valid_i;
  logic [N_REQ*DATA_WIDTH-1:0] req_data_i;
  logic [N_REQ-1:0]            req_ready_o;
  logic                        fifo_full_i;
  logic                        fifo_wr_en_o;
  logic [DATA_WIDTH-1:0]       fifo_data_o;
  logic [N_REQ-1:0]            grant_o;
  logic [ID_W-1:0]             grant_id_o;
  logic                        busy_o;

  typedef struct packed {
    logic [ID_W-1:0]       id;
    logic [DATA_WIDTH-1:0] data;
  } beat_t;

  typedef struct packed {
    logic [N_REQ-1:0] grant;
    logic [N_REQ-1:0] ready;
    logic             wr_en;
    logic             busy;
  } snap_t;

  beat_t                 exp_q[$];
  logic [DATA_WIDTH-1:0] prod_q[N_REQ][$];
  snap_t                 hist[$];
  bit                    full_sched[$];
  bit                    rand_full;
  int                    model_ptr;
  int                    checks;
  int                    errors;

  fifo_wr_arbiter #(
    .N_REQ(N_REQ), .DATA_WIDTH(DATA_WIDTH), .MAX_BURST(MAX_BURST)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .fifo_full_i(fifo_full_i), .fifo_wr_en_o(fifo_wr_en_o), .fifo_data_o(fifo_data_o),
    .grant_o(grant_o), .grant_id_o(grant_id_o), .busy_o(busy_o)
  );

  // Free-running clock
  always #5 clk_i = ~clk_i;

  // Single comparison point. Every check goes through here.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model. Round-robin over producers with pending words. Each
  // grant drains min(MAX_BURST, remaining) words. Backpressure changes only
  // the timing, never the order.
  function automatic void rebuildExpected();
    int    rem[N_REQ];
    int    pos[N_REQ];
    int    found;
    int    p;
    int    n;
    beat_t b;
    exp_q.delete();
    for (int i = 0; i < N_REQ; i++) begin
      rem[i] = prod_q[i].size();
      pos[i] = 0;
    end
    do begin
      found = -1;
      for (int k = 1; k <= N_REQ; k++) begin
        p = (model_ptr + k) % N_REQ;
        if (found < 0 && rem[p] > 0) found = p;
      end
      if (found >= 0) begin
        n = (rem[found] < MAX_BURST) ? rem[found] : MAX_BURST;
        for (int j = 0; j < n; j++) begin
          b.id   = found[ID_W-1:0];
          b.data = prod_q[found][pos[found] + j];
          exp_q.push_back(b);
        end
        pos[found] += n;
        rem[found] -= n;
        model_ptr   = found;
      end
    end while (found >= 0);
  endfunction

  // Present the head of every producer queue and choose this cycle's
  // FIFO-full value.
  task automatic driveInputs();
    for (int i = 0; i < N_REQ; i++) begin
      req_valid_i[i] = (prod_q[i].size() > 0);
      req_data_i[i*DATA_WIDTH +: DATA_WIDTH] = (prod_q[i].size() > 0) ? prod_q[i][0] : '0;
    end
    if (full_sched.size() > 0)
      fifo_full_i = full_sched.pop_front();
    else if (rand_full)
      fifo_full_i = ($urandom_range(0, 99) < 30);
    else
      fifo_full_i = 1'b0;
  endtask

  // One clock of producer behaviour. Record the handshakes at negedge,
  // then retire the accepted words just after the posedge.
  task automatic applyStimulus();
    logic [N_REQ-1:0] xfer;
    @(negedge clk_i);
    xfer = req_valid_i & req_ready_o;
    @(posedge clk_i);
    #1;
    for (int i = 0; i < N_REQ; i++)
      if (xfer[i]) void'(prod_q[i].pop_front());
    driveInputs();
  endtask

  function automatic bit anyPending();
    bit r = 1'b0;
    for (int i = 0; i < N_REQ; i++)
      if (prod_q[i].size() > 0) r = 1'b1;
    return r;
  endfunction

  // Grant value at the start of the n-th burst seen in the history.
  function automatic logic [N_REQ-1:0] nthOwner(int n);
    logic [N_REQ-1:0] prev = '0;
    logic [N_REQ-1:0] res  = '0;
    int               cnt  = 0;
    foreach (hist[c]) begin
      if (hist[c].grant != '0 && prev == '0) begin
        if (cnt == n) res = hist[c].grant;
        cnt++;
      end
      prev = hist[c].grant;
    end
    return res;
  endfunction

  // Check the reset values with reset held, then release reset.
  task automatic resetDut();
    rst_ni = 1'b0;
    for (int i = 0; i < N_REQ; i++) prod_q[i].delete();
    full_sched.delete();
    rand_full = 1'b0;
    exp_q.delete();
    driveInputs();
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("rst_grant", 32'(grant_o), 0);
    checkOutput("rst_grant_id", 32'(grant_id_o), 0);
    checkOutput("rst_busy", 32'(busy_o), 0);
    checkOutput("rst_ready", 32'(req_ready_o), 0);
    checkOutput("rst_wr_en", 32'(fifo_wr_en_o), 0);
    rst_ni    = 1'b1;
    model_ptr = N_REQ - 1;
  endtask

  task automatic startPhase();
    rebuildExpected();
    hist.delete();
    driveInputs();
  endtask

  // Run until every word is delivered, then idle briefly and confirm the
  // arbiter has gone back to IDLE.
  task automatic runPhase(input string name, input int budget);
    int cyc = 0;
    while ((exp_q.size() != 0 || anyPending()) && cyc < budget) begin
      applyStimulus();
      cyc++;
    end
    checkOutput({name, "_drained"}, 32'(exp_q.size()), 0);
    repeat (3) applyStimulus();
    checkOutput({name, "_idle_busy"}, 32'(busy_o), 0);
    checkOutput({name, "_idle_grant"}, 32'(grant_o), 0);
  endtask

  // Monitor. Record a snapshot each cycle, check the combinational port
  // rules, and score every FIFO write against the expected queue.
  always @(negedge clk_i) begin
    snap_t s;
    beat_t b;
    if (rst_ni === 1'b1) begin
      s.grant = grant_o;
      s.ready = req_ready_o;
      s.wr_en = fifo_wr_en_o;
      s.busy  = busy_o;
      hist.push_back(s);
      checkOutput("grant_onehot", 32'($onehot0(grant_o)), 1);
      checkOutput("ready_rule", 32'(req_ready_o),
                  32'((busy_o && !fifo_full_i) ? grant_o : '0));
      checkOutput("wr_en_rule", 32'(fifo_wr_en_o), 32'(|(req_valid_i & req_ready_o)));
      if (!busy_o) checkOutput("idle_data", 32'(fifo_data_o), 0);
      if (fifo_wr_en_o) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", 32'(fifo_data_o), 32'hFFFF_FFFF);
        end else begin
          b = exp_q.pop_front();
          checkOutput("wr_id", 32'(grant_id_o), 32'(b.id));
          checkOutput("wr_data", 32'(fifo_data_o), 32'(b.data));
          checkOutput("wr_not_full", 32'(fifo_full_i), 0);
        end
      end
    end
  end

  // Global time limit so that a hung DUT still ends the run.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios followed by randomized rounds.
  initial begin
    int t1g[9];
    int t1w[9];
    int t3g[11];
    int t3w[11];
    int first_wr;
    int last_wr;
    int nwr;
    int cyc;
    checks      = 0;
    errors      = 0;
    rst_ni      = 1'b0;
    req_valid_i = '0;
    req_data_i  = '0;
    fifo_full_i = 1'b0;
    resetDut();

    // Single producer: a 4-beat burst, a bubble, then a re-grant for the last word
    $display("[TB] single requester burst");
    for (int j = 0; j < 5; j++) prod_q[0].push_back(8'(8'hA0 + j));
    startPhase();
    runPhase("t1", 200);
    t1g = '{0, 1, 1, 1, 1, 0, 1, 1, 0};
    t1w = '{0, 1, 1, 1, 1, 0, 1, 0, 0};
    checkOutput("t1_hist_len", 32'(hist.size() >= 9), 1);
    for (int c = 0; c < 9; c++) begin
      if (c < hist.size()) begin
        checkOutput($sformatf("t1_grant_c%0d", c), 32'(hist[c].grant), 32'(t1g[c]));
        checkOutput($sformatf("t1_wr_c%0d", c), 32'(hist[c].wr_en), 32'(t1w[c]));
      end
    end

    // All producers busy: order 0,1,2,3,..., 4-beat bursts, one bubble between bursts
    $display("[TB] all requesters continuous");
    resetDut();
    for (int i = 0; i < N_REQ; i++)
      for (int j = 0; j < 8; j++) prod_q[i].push_back(8'((i << 4) | j));
    startPhase();
    runPhase("t2", 400);
    first_wr = -1;
    last_wr  = -1;
    nwr      = 0;
    foreach (hist[c]) begin
      if (hist[c].wr_en) begin
        if (first_wr < 0) first_wr = c;
        last_wr = c;
        nwr++;
      end
    end
    checkOutput("t2_first_wr", 32'(first_wr), 1);
    checkOutput("t2_write_count", 32'(nwr), 32);
    checkOutput("t2_span", 32'(last_wr - first_wr + 1), 39);
    checkOutput("t2_owner0", 32'(nthOwner(0)), 32'h1);
    checkOutput("t2_owner4", 32'(nthOwner(4)), 32'h1);

    // FIFO full for 5 cycles after beat 2 of req2's burst
    $display("[TB] full backpressure mid-burst");
    for (int j = 0; j < 4; j++) prod_q[2].push_back(8'(8'hC0 + j));
    full_sched = '{0, 0, 0, 1, 1, 1, 1, 1};
    startPhase();
    runPhase("t3", 200);
    t3g = '{0, 4, 4, 4, 4, 4, 4, 4, 4, 4, 0};
    t3w = '{0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0};
    checkOutput("t3_hist_len", 32'(hist.size() >= 11), 1);
    for (int c = 0; c < 11; c++) begin
      if (c < hist.size()) begin
        checkOutput($sformatf("t3_grant_c%0d", c), 32'(hist[c].grant), 32'(t3g[c]));
        checkOutput($sformatf("t3_wr_c%0d", c), 32'(hist[c].wr_en), 32'(t3w[c]));
        if (c >= 3 && c <= 7)
          checkOutput($sformatf("t3_ready_c%0d", c), 32'(hist[c].ready), 0);
      end
    end

    // Owner req1 goes idle after 2 beats: the pointer moves to 1, so req3 beats req0
    $display("[TB] early release");
    prod_q[0].push_back(8'h55);
    startPhase();
    runPhase("t4a", 100);
    for (int j = 0; j < 2; j++) begin
      prod_q[0].push_back(8'(8'h00 + j));
      prod_q[1].push_back(8'(8'h10 + j));
      prod_q[3].push_back(8'(8'h30 + j));
    end
    startPhase();
    runPhase("t4b", 200);
    checkOutput("t4_owner0", 32'(nthOwner(0)), 32'h2);
    checkOutput("t4_owner1", 32'(nthOwner(1)), 32'h8);
    checkOutput("t4_owner2", 32'(nthOwner(2)), 32'h1);

    // Async reset during beat 3 of req2's burst
    $display("[TB] async reset mid-burst");
    for (int j = 0; j < 8; j++) prod_q[2].push_back(8'(8'hE0 + j));
    startPhase();
    cyc = 0;
    while (prod_q[2].size() > 6 && cyc < 50) begin
      applyStimulus();
      cyc++;
    end
    checkOutput("t5_reached_beat3", 32'(prod_q[2].size()), 6);
    rst_ni = 1'b0;
    #1;
    checkOutput("t5_rst_grant", 32'(grant_o), 0);
    checkOutput("t5_rst_wr_en", 32'(fifo_wr_en_o), 0);
    checkOutput("t5_rst_ready", 32'(req_ready_o), 0);
    checkOutput("t5_rst_busy", 32'(busy_o), 0);
    checkOutput("t5_rst_data", 32'(fifo_data_o), 0);
    checkOutput("t5_rst_grant_id", 32'(grant_id_o), 0);
    for (int j = 0; j < 3; j++) prod_q[0].push_back(8'(8'h70 + j));
    driveInputs();
    applyStimulus();
    applyStimulus();
    rst_ni    = 1'b1;
    model_ptr = N_REQ - 1;
    startPhase();
    runPhase("t5", 200);
    checkOutput("t5_owner0", 32'(nthOwner(0)), 32'h1);
    checkOutput("t5_owner1", 32'(nthOwner(1)), 32'h4);

    // Random producer loads with random FIFO backpressure
    $display("[TB] randomized rounds");
    rand_full = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N_REQ; i++) begin
        int n = $urandom_range(0, 10);
        for (int j = 0; j < n; j++) prod_q[i].push_back(8'($urandom));
      end
      startPhase();
      runPhase($sformatf("rand%0d", r), 2000);
    end
    rand_full = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
